// File: rtl/controller.sv
// Two-way traffic-light controller with pedestrian request latching.
// Six-phase fixed cycle timed by one up-counting phase timer; lamp drives and
// pedestrian wait flags are registered.
// Optional build macro: PED_EARLY_EXIT_EN -- when defined, a pending request
// for the cross direction shortens the current green to MIN_GREEN_S.
//
// state        | meaning
// -------------+-----------------------------------------------
// S_NS_GREEN   | NS green, EW red (reset state)
// S_NS_YELLOW  | NS yellow, EW red
// S_ALLRED_1   | both red, clearance before EW green
// S_EW_GREEN   | EW green, NS red
// S_EW_YELLOW  | EW yellow, NS red
// S_ALLRED_2   | both red, clearance before NS green
module controller #(
    parameter int CLK_FREQ    = 5,
    parameter int GREEN_S     = 10,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int MIN_GREEN_S = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_NS,
    input  logic ped_EW,
    output logic NS_red,
    output logic NS_yellow,
    output logic NS_green,
    output logic EW_red,
    output logic EW_yellow,
    output logic EW_green,
    output logic ped_wait_NS,
    output logic ped_wait_EW
);

    localparam int G_CYC   = GREEN_S * CLK_FREQ;
    localparam int Y_CYC   = YELLOW_S * CLK_FREQ;
    localparam int A_CYC   = ALLRED_S * CLK_FREQ;
    localparam int M_CYC   = MIN_GREEN_S * CLK_FREQ;
    // Size for the longest phase so non-default parameter sets cannot wrap.
    localparam int GY_MAX  = (G_CYC > Y_CYC) ? G_CYC : Y_CYC;
    localparam int MAX_CYC = (GY_MAX > A_CYC) ? GY_MAX : A_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] G_LAST = TW'(G_CYC - 1);
    localparam logic [TW-1:0] Y_LAST = TW'(Y_CYC - 1);
    localparam logic [TW-1:0] A_LAST = TW'(A_CYC - 1);
    localparam logic [TW-1:0] M_LAST = TW'(M_CYC - 1);

`ifdef PED_EARLY_EXIT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_ALLRED_1  = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_ALLRED_2  = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          ns_green_done;
    logic          ew_green_done;
    logic          enter_ns_green;
    logic          enter_ew_green;

    // Lamp pattern {NS r,y,g, EW r,y,g} for a given state.
    function automatic logic [5:0] lamps_of(input state_t s);
        logic [5:0] l;
        l = 6'b001_100;
        case (s)
            S_NS_GREEN:  l = 6'b001_100;
            S_NS_YELLOW: l = 6'b010_100;
            S_ALLRED_1:  l = 6'b100_100;
            S_EW_GREEN:  l = 6'b100_001;
            S_EW_YELLOW: l = 6'b100_010;
            S_ALLRED_2:  l = 6'b100_100;
            default:     l = 6'b001_100;
        endcase
        return l;
    endfunction

    // Green end: full duration, or early once the minimum has elapsed and the
    // cross direction is waiting (a late request ends the phase on the next edge).
    always_comb begin
        ns_green_done = (timer == G_LAST) ||
                        (EARLY_EN && ped_wait_EW && (timer >= M_LAST));
        ew_green_done = (timer == G_LAST) ||
                        (EARLY_EN && ped_wait_NS && (timer >= M_LAST));
    end

    // Next-state selection for the six-phase cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_NS_GREEN:  if (ns_green_done)   state_nxt = S_NS_YELLOW;
            S_NS_YELLOW: if (timer == Y_LAST) state_nxt = S_ALLRED_1;
            S_ALLRED_1:  if (timer == A_LAST) state_nxt = S_EW_GREEN;
            S_EW_GREEN:  if (ew_green_done)   state_nxt = S_EW_YELLOW;
            S_EW_YELLOW: if (timer == Y_LAST) state_nxt = S_ALLRED_2;
            S_ALLRED_2:  if (timer == A_LAST) state_nxt = S_NS_GREEN;
            default:                          state_nxt = S_NS_GREEN;
        endcase
    end

    // Entering a green serves that direction's request, even one arriving now.
    always_comb begin
        enter_ns_green = (state_nxt == S_NS_GREEN) && (state != S_NS_GREEN);
        enter_ew_green = (state_nxt == S_EW_GREEN) && (state != S_EW_GREEN);
    end

    // State, phase timer, registered lamps and pedestrian wait flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_NS_GREEN;
            timer       <= '0;
            ped_wait_NS <= 1'b0;
            ped_wait_EW <= 1'b0;
            {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green} <= lamps_of(S_NS_GREEN);
        end else begin
            state <= state_nxt;
            timer <= (state_nxt != state) ? '0 : timer + TW'(1);
            {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green} <= lamps_of(state_nxt);

            if (enter_ns_green)
                ped_wait_NS <= 1'b0;
            else if (ped_NS && (state != S_NS_GREEN))
                ped_wait_NS <= 1'b1;

            if (enter_ew_green)
                ped_wait_EW <= 1'b0;
            else if (ped_EW && (state != S_EW_GREEN))
                ped_wait_EW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller at default parameters.
// Honours PED_EARLY_EXIT_EN when the bundle is built with it.
module tb_controller;

    localparam int GC = 50;
    localparam int YC = 15;
    localparam int AC = 5;
    localparam int MC = 20;
`ifdef PED_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [5:0] L_NSG = 6'b001_100;
    localparam logic [5:0] L_NSY = 6'b010_100;
    localparam logic [5:0] L_AR  = 6'b100_100;
    localparam logic [5:0] L_EWG = 6'b100_001;
    localparam logic [5:0] L_EWY = 6'b100_010;

    logic clk = 1'b0;
    logic rst, ped_NS, ped_EW;
    logic NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green;
    logic ped_wait_NS, ped_wait_EW;
    logic [5:0] lamps;

    assign lamps = {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green};

    controller dut (
        .clk(clk), .rst(rst), .ped_NS(ped_NS), .ped_EW(ped_EW),
        .NS_red(NS_red), .NS_yellow(NS_yellow), .NS_green(NS_green),
        .EW_red(EW_red), .EW_yellow(EW_yellow), .EW_green(EW_green),
        .ped_wait_NS(ped_wait_NS), .ped_wait_EW(ped_wait_EW)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase index, edge count, entry edge of current phase.
    // A phase entered at edge e ends at edge e+duration; an early green ends at
    // max(e+min, n) once the cross wait is seen pending before edge n.
    int         m_phase, m_entry, m_n;
    bit         m_wns, m_wew;
    int         m_dur [6];
    logic [5:0] m_lamp [6];

    task automatic m_reset();
        m_phase = 0; m_entry = 0; m_n = 0; m_wns = 0; m_wew = 0;
    endtask

    task automatic m_edge(input bit pns, input bit pew);
        int end_at, early_at, nxt;
        m_n++;
        end_at = m_entry + m_dur[m_phase];
        if (EARLY && ((m_phase == 0 && m_wew) || (m_phase == 3 && m_wns))) begin
            early_at = (m_entry + MC > m_n) ? m_entry + MC : m_n;
            if (early_at < end_at) end_at = early_at;
        end
        nxt = (m_n == end_at) ? (m_phase + 1) % 6 : m_phase;
        if (nxt == 0 && m_phase != 0) m_wns = 0;
        else if (pns && m_phase != 0) m_wns = 1;
        if (nxt == 3 && m_phase != 3) m_wew = 0;
        else if (pew && m_phase != 3) m_wew = 1;
        if (nxt != m_phase) m_entry = m_n;
        m_phase = nxt;
    endtask

    task automatic step();
        m_edge(ped_NS, ped_EW);
        @(posedge clk);
        #1;
        chk("model_lamps", {26'd0, lamps}, {26'd0, m_lamp[m_phase]});
        chk("model_waits", {30'd0, ped_wait_NS, ped_wait_EW}, {30'd0, m_wns, m_wew});
    endtask

    task automatic reset_dut();
        rst = 1'b1; ped_NS = 1'b0; ped_EW = 1'b0;
        m_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run_until(input logic [5:0] pat, input string name);
        int k;
        k = 0;
        while (lamps !== pat && k < 300) begin
            step();
            k++;
        end
        chk(name, {26'd0, lamps}, {26'd0, pat});
    endtask

    task automatic ns_green_len(input int already, output int len);
        len = already;
        while (NS_green === 1'b1 && len < 300) begin
            step();
            len++;
        end
    endtask

    typedef struct {
        string      name;
        logic [5:0] lamps;
        int         cycles;
    } vec_t;
    vec_t tab [12];

    int age_ns, age_ew;

    task automatic rand_step();
        step();
        chk("lamp_conflict",
            {31'd0, ($countones(lamps[5:3]) == 1) && ($countones(lamps[2:0]) == 1) &&
                    !((lamps[4] | lamps[3]) && (lamps[1] | lamps[0]))}, 32'd1);
        age_ns = ped_wait_NS ? age_ns + 1 : 0;
        age_ew = ped_wait_EW ? age_ew + 1 : 0;
        chk("wait_ns_age", {31'd0, age_ns <= 140}, 32'd1);
        chk("wait_ew_age", {31'd0, age_ew <= 140}, 32'd1);
    endtask

    initial begin
        int len, gap, sel;
        m_dur  = '{GC, YC, AC, GC, YC, AC};
        m_lamp = '{L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};
        tab[0]  = '{"ns_green",  L_NSG, GC};
        tab[1]  = '{"ns_yellow", L_NSY, YC};
        tab[2]  = '{"allred_1",  L_AR,  AC};
        tab[3]  = '{"ew_green",  L_EWG, GC};
        tab[4]  = '{"ew_yellow", L_EWY, YC};
        tab[5]  = '{"allred_2",  L_AR,  AC};
        for (int i = 6; i < 12; i++) tab[i] = tab[i-6];

        // Reset values without any clock edge.
        rst = 1'b1; ped_NS = 1'b0; ped_EW = 1'b0;
        m_reset();
        #1;
        chk("reset_lamps", {26'd0, lamps}, {26'd0, L_NSG});
        chk("reset_waits", {30'd0, ped_wait_NS, ped_wait_EW}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Phase timing with no requests, two full cycles.
        for (int i = 0; i < 12; i++)
            for (int c = 0; c < tab[i].cycles; c++) begin
                chk(tab[i].name, {26'd0, lamps}, {26'd0, tab[i].lamps});
                step();
            end
        chk("cycle_wrap", {26'd0, lamps}, {26'd0, L_NSG});

        // ped_EW pulse at cycle 3 of NS green.
        reset_dut();
        repeat (3) step();
        ped_EW = 1'b1; step(); ped_EW = 1'b0;
        chk("ew_wait_set", {31'd0, ped_wait_EW}, 32'd1);
        ns_green_len(4, len);
        chk("ns_green_len_req", len, EARLY ? MC : GC);
        run_until(L_EWG, "reach_ew_green");
        chk("ew_wait_cleared", {31'd0, ped_wait_EW}, 32'd0);

        // ped_NS during NS green is ignored.
        reset_dut();
        repeat (5) step();
        ped_NS = 1'b1; step(); ped_NS = 1'b0;
        chk("ns_wait_ignored", {31'd0, ped_wait_NS}, 32'd0);
        ns_green_len(6, len);
        chk("ns_green_len_ign", len, GC);

        // Simultaneous requests during ALLRED_1.
        reset_dut();
        run_until(L_AR, "reach_allred_1");
        ped_NS = 1'b1; ped_EW = 1'b1; step(); ped_NS = 1'b0; ped_EW = 1'b0;
        chk("both_waits_set", {30'd0, ped_wait_NS, ped_wait_EW}, 32'd3);
        run_until(L_EWG, "reach_ew_green2");
        chk("ew_clr_ns_keep", {30'd0, ped_wait_NS, ped_wait_EW}, 32'd2);
        run_until(L_NSG, "reach_ns_green");
        chk("ns_wait_cleared", {31'd0, ped_wait_NS}, 32'd0);

        // Asynchronous reset mid EW yellow with a request pending.
        reset_dut();
        run_until(L_EWY, "reach_ew_yellow");
        ped_NS = 1'b1; step(); ped_NS = 1'b0;
        chk("ns_wait_pending", {31'd0, ped_wait_NS}, 32'd1);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lamps", {26'd0, lamps}, {26'd0, L_NSG});
        chk("async_rst_waits", {30'd0, ped_wait_NS, ped_wait_EW}, 32'd0);
        m_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        ns_green_len(0, len);
        chk("ns_green_after_rst", len, GC);

        // Random pulses against the model.
        reset_dut();
        age_ns = 0; age_ew = 0;
        for (int p = 0; p < 100; p++) begin
            gap = $urandom_range(5, 20);
            repeat (gap) rand_step();
            sel = $urandom_range(1, 3);
            ped_NS = sel[0]; ped_EW = sel[1];
            rand_step();
            ped_NS = 1'b0; ped_EW = 1'b0;
        end
        repeat (150) rand_step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
